// File: rtl/riscv_mem_stage.sv
// rtl/riscv_mem_stage.sv - MEM stage: ALU pass-through plus load/store over a req/gnt/rvalid data bus
module riscv_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rd_we,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  wb_a,
    output logic [31:0] wb_d,
    output logic        wb_e,
    output logic        mem_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // A zero timeout disables the watchdog; TO_LAST is the count seen on the final allowed cycle.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        rd_q;
    logic              rd_we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [31:0]       dmem_addr_q;
    logic [3:0]        dmem_be_q;
    logic [31:0]       dmem_wdata_q;
    logic [4:0]        wb_a_q;
    logic [31:0]       wb_d_q;
    logic              wb_e_q;
    logic              mem_fault_q;

    logic [1:0]        acc_off;
    logic [3:0]        acc_be_d;
    logic [31:0]       acc_wdata_d;
    logic              acc_misalign;
    logic              acc_f3_ok;
    logic              acc_legal;
    logic [31:0]       lane;
    logic [31:0]       load_ext;

    // Decode the incoming memory op: byte enables, replicated store data and legality.
    always_comb begin
        acc_off      = ex_alu_res[1:0];
        acc_be_d     = 4'b0000;
        acc_wdata_d  = ex_rs2_data;
        acc_misalign = 1'b0;
        case (ex_funct3[1:0])
            2'b00: begin
                acc_be_d    = 4'b0001 << acc_off;
                acc_wdata_d = {4{ex_rs2_data[7:0]}};
            end
            2'b01: begin
                acc_be_d     = 4'b0011 << acc_off;
                acc_wdata_d  = {2{ex_rs2_data[15:0]}};
                acc_misalign = acc_off[0];
            end
            2'b10: begin
                acc_be_d     = 4'b1111;
                acc_misalign = (acc_off != 2'b00);
            end
            default: ;
        endcase
        if (ex_mem_read && ex_mem_write) begin
            acc_f3_ok = 1'b0;
        end else if (ex_mem_read) begin
            acc_f3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                        (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
        end else begin
            acc_f3_ok = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
        end
        acc_legal = acc_f3_ok && !acc_misalign;
    end

    // Pick the addressed lane out of the returned word and extend it to 32 bits.
    always_comb begin
        lane = dmem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h000000, lane[7:0]};
            3'b101:  load_ext = {16'h0000, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Stage FSM: accept ops, run the bus handshake, retire writebacks and report faults.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_q         <= 5'd0;
            rd_we_q      <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= 32'd0;
            wb_a_q       <= 5'd0;
            wb_d_q       <= 32'd0;
            wb_e_q       <= 1'b0;
            mem_fault_q  <= 1'b0;
        end else begin
            wb_e_q      <= 1'b0;
            mem_fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!ex_mem_read && !ex_mem_write) begin
                            wb_a_q <= ex_rd;
                            wb_d_q <= ex_alu_res;
                            wb_e_q <= ex_rd_we && (ex_rd != 5'd0);
                        end else begin
                            rd_q         <= ex_rd;
                            rd_we_q      <= ex_rd_we;
                            funct3_q     <= ex_funct3;
                            off_q        <= acc_off;
                            dmem_we_q    <= ex_mem_write;
                            dmem_addr_q  <= {ex_alu_res[31:2], 2'b00};
                            dmem_be_q    <= acc_be_d;
                            dmem_wdata_q <= acc_wdata_d;
                            if (acc_legal) begin
                                state_q    <= S_REQ;
                                dmem_req_q <= 1'b1;
                                cnt_q      <= '0;
                            end else begin
                                mem_fault_q <= 1'b1;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= dmem_we_q ? S_IDLE : S_RESP;
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        dmem_req_q  <= 1'b0;
                        mem_fault_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid) begin
                        wb_a_q  <= rd_q;
                        wb_d_q  <= load_ext;
                        wb_e_q  <= rd_we_q && (rd_q != 5'd0);
                        state_q <= S_IDLE;
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        mem_fault_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ex_ready   = (state_q == S_IDLE);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_a       = wb_a_q;
    assign wb_d       = wb_d_q;
    assign wb_e       = wb_e_q;
    assign mem_fault  = mem_fault_q;

endmodule

// File: tb/tb_riscv_mem_stage.sv
// tb/tb_riscv_mem_stage.sv - self-checking bench for riscv_mem_stage
module tb_riscv_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        wb_e;
    logic        mem_fault;

    riscv_mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_res(ex_alu_res),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_a(wb_a), .wb_d(wb_d), .wb_e(wb_e), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    // Expected outputs after the coming rising edge
    bit          chk_on = 1'b0;
    bit          m_ready, m_wb_e, m_fault, m_req, m_we, m_zero, m_lit_en;
    logic [4:0]  m_wb_a;
    logic [31:0] m_wb_d, m_addr, m_wdata, m_lit;
    logic [3:0]  m_be, m_lit_be;
    int          n_checks = 0;
    int          n_err = 0;

    typedef struct {
        bit          rd_;
        bit          wr_;
        logic [2:0]  f;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        bit          we;
        int          gnt_dly;
        int          rv_dly;
        bit          abort;
        bit          lit_en;
        logic [31:0] lit;
        logic [3:0]  lit_be;
    } op_t;

    op_t o;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        case (a - (a % 4))
            32'h0:   return 32'hDEADBEEF;
            32'h4:   return 32'h12345678;
            32'hC:   return 32'hFEDCBA98;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic int m_size(logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit m_legal(bit r, bit w, logic [2:0] f, logic [31:0] a);
        int sz;
        if (r && w) return 1'b0;
        if (r && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 1'b0;
        if (w && !(f == 0 || f == 1 || f == 2)) return 1'b0;
        sz = m_size(f);
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] m_bemask(logic [2:0] f, logic [31:0] a);
        logic [7:0] t;
        t = 8'(((1 << m_size(f)) - 1) << (a % 4));
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wdat(logic [2:0] f, logic [31:0] d);
        int sz;
        sz = m_size(f);
        if (sz == 1) return {24'h0, d[7:0]} * 32'h01010101;
        if (sz == 2) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_ext(logic [2:0] f, logic [31:0] a, logic [31:0] w);
        int          sz;
        logic [31:0] v, mask;
        sz = m_size(f);
        v  = w >> (8 * (a % 4));
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (f[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic op_t mk(bit r, bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d,
                               logic [4:0] rd, int g, int v, bit le, logic [31:0] lit, logic [3:0] lbe);
        op_t t;
        t.rd_ = r; t.wr_ = w; t.f = f; t.addr = a; t.rs2 = d; t.rd = rd; t.we = 1'b1;
        t.gnt_dly = g; t.rv_dly = v; t.abort = 1'b0; t.lit_en = le; t.lit = lit; t.lit_be = lbe;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model expectations
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_on) begin
                chk("ex_ready", 32'(ex_ready), 32'(m_ready));
                chk("wb_e", 32'(wb_e), 32'(m_wb_e));
                chk("mem_fault", 32'(mem_fault), 32'(m_fault));
                chk("dmem_req", 32'(dmem_req), 32'(m_req));
                if (m_wb_e) begin
                    chk("wb_a", 32'(wb_a), 32'(m_wb_a));
                    chk("wb_d", wb_d, m_wb_d);
                    if (m_lit_en) chk("wb_d_lit", wb_d, m_lit);
                end
                if (m_zero) begin
                    chk("wb_a_rst", 32'(wb_a), 32'd0);
                    chk("wb_d_rst", wb_d, 32'd0);
                end
                if (m_req) begin
                    chk("dmem_we", 32'(dmem_we), 32'(m_we));
                    chk("dmem_addr", dmem_addr, m_addr);
                    chk("dmem_be", 32'(dmem_be), 32'(m_be));
                    if (m_we) chk("dmem_wdata", dmem_wdata, m_wdata);
                    if (m_lit_en && m_we) begin
                        chk("be_lit", 32'(dmem_be), 32'(m_lit_be));
                        chk("wdata_lit", dmem_wdata, m_lit);
                    end
                end
            end
        end
    end

    task automatic set_idle();
        reset        = 1'b0;
        ex_valid     = 1'b0;
        ex_alu_res   = 32'h0BAD0BAD;
        ex_rs2_data  = 32'h77777777;
        ex_rd        = 5'd31;
        ex_rd_we     = 1'b1;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_funct3    = 3'd7;
        dmem_gnt     = 1'b0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = 32'h5A5A5A5A;
        m_wb_e = 1'b0; m_fault = 1'b0; m_req = 1'b0; m_ready = 1'b1;
        m_lit_en = 1'b0; m_zero = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_idle();
            reset  = 1'b1;
            m_zero = 1'b1;
            chk_on = 1'b1;
        end
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] res, input bit we,
                       input bit le, input logic [31:0] lit);
        @(negedge clk);
        set_idle();
        ex_valid = 1'b1; ex_rd = rd; ex_alu_res = res; ex_rd_we = we; ex_funct3 = 3'b010;
        m_wb_e = we && (rd != 5'd0); m_wb_a = rd; m_wb_d = res;
        m_lit_en = le; m_lit = lit;
    endtask

    task automatic mem_op(input op_t op);
        bit granted, timed, finished;
        @(negedge clk);
        set_idle();
        ex_valid = 1'b1; ex_mem_read = op.rd_; ex_mem_write = op.wr_; ex_funct3 = op.f;
        ex_alu_res = op.addr; ex_rs2_data = op.rs2; ex_rd = op.rd; ex_rd_we = op.we;
        if (!m_legal(op.rd_, op.wr_, op.f, op.addr)) begin
            m_fault = 1'b1;
            return;
        end
        m_req = 1'b1; m_ready = 1'b0; m_we = op.wr_;
        m_addr = op.addr - (op.addr % 4);
        m_be = m_bemask(op.f, op.addr);
        m_wdata = m_wdat(op.f, op.rs2);
        m_lit_en = op.lit_en; m_lit = op.lit; m_lit_be = op.lit_be;
        granted = 1'b0; timed = 1'b0;
        for (int k = 0; k < 64 && !granted && !timed; k++) begin
            @(negedge clk);
            set_idle();
            m_ready = 1'b0;
            if (k == op.gnt_dly) begin
                dmem_gnt = 1'b1; m_ready = op.wr_; granted = 1'b1;
            end else if (k == TO - 1) begin
                m_fault = 1'b1; m_ready = 1'b1; timed = 1'b1;
            end else begin
                m_req = 1'b1; m_lit_en = op.lit_en;
                dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
            end
        end
        if (granted && op.rd_) begin
            finished = 1'b0;
            for (int j = 0; j < 64 && !finished; j++) begin
                @(negedge clk);
                set_idle();
                m_ready = 1'b0;
                if (op.abort) begin
                    reset = 1'b1; m_zero = 1'b1; m_ready = 1'b1; finished = 1'b1;
                end else if (j == op.rv_dly) begin
                    dmem_rvalid = 1'b1; dmem_rdata = mem_word(op.addr);
                    m_wb_e = op.we && (op.rd != 5'd0); m_wb_a = op.rd;
                    m_wb_d = m_ext(op.f, op.addr, mem_word(op.addr));
                    m_ready = 1'b1; m_lit_en = op.lit_en; m_lit = op.lit; finished = 1'b1;
                end else if (j == TO - 1) begin
                    m_fault = 1'b1; m_ready = 1'b1; finished = 1'b1;
                end else begin
                    dmem_gnt = 1'b1;
                end
            end
            if (op.abort) begin
                @(negedge clk);
                set_idle();
                dmem_rvalid = 1'b1; dmem_rdata = mem_word(op.addr);
            end
        end
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        do_reset(2);
        // T1: ALU pass-through, back to back
        alu(5'd5, 32'h0000002A, 1'b1, 1'b1, 32'h0000002A);
        alu(5'd6, 32'h00000100, 1'b1, 1'b1, 32'h00000100);
        alu(5'd7, 32'h00000055, 1'b0, 1'b0, 32'h0);
        alu(5'd0, 32'h00000077, 1'b1, 1'b0, 32'h0);
        alu(5'd9, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF);
        // T2: LW with delayed grant and response
        mem_op(mk(1, 0, 3'b010, 32'h0, 32'h0, 5'd1, 2, 1, 1, 32'hDEADBEEF, 4'h0));
        // T3: sub-word loads
        mem_op(mk(1, 0, 3'b000, 32'h3, 32'h0, 5'd2, 0, 0, 1, 32'hFFFFFFDE, 4'h0));
        mem_op(mk(1, 0, 3'b101, 32'h6, 32'h0, 5'd3, 1, 0, 1, 32'h00001234, 4'h0));
        mem_op(mk(1, 0, 3'b001, 32'hE, 32'h0, 5'd4, 0, 2, 1, 32'hFFFFFEDC, 4'h0));
        mem_op(mk(1, 0, 3'b100, 32'h1, 32'h0, 5'd8, 0, 0, 1, 32'h000000BE, 4'h0));
        mem_op(mk(1, 0, 3'b010, 32'hC, 32'h0, 5'd10, 0, 0, 1, 32'hFEDCBA98, 4'h0));
        alu(5'd11, 32'h00000123, 1'b1, 1'b0, 32'h0);
        // T4: stores and a misaligned store
        mem_op(mk(0, 1, 3'b000, 32'h9, 32'h000000AB, 5'd0, 1, 0, 1, 32'hABABABAB, 4'b0010));
        mem_op(mk(0, 1, 3'b001, 32'h5, 32'h00001234, 5'd0, 0, 0, 0, 32'h0, 4'h0));
        mem_op(mk(0, 1, 3'b001, 32'h2, 32'h00001234, 5'd0, 0, 0, 1, 32'h12341234, 4'b1100));
        mem_op(mk(0, 1, 3'b010, 32'h4, 32'hCAFEF00D, 5'd0, 2, 0, 1, 32'hCAFEF00D, 4'b1111));
        // T5: rd=0 load, illegal funct3, misaligned word, read+write
        mem_op(mk(1, 0, 3'b010, 32'h4, 32'h0, 5'd0, 0, 1, 0, 32'h0, 4'h0));
        mem_op(mk(1, 0, 3'b011, 32'h4, 32'h0, 5'd12, 0, 0, 0, 32'h0, 4'h0));
        mem_op(mk(1, 0, 3'b110, 32'h0, 32'h0, 5'd12, 0, 0, 0, 32'h0, 4'h0));
        mem_op(mk(0, 1, 3'b011, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 4'h0));
        mem_op(mk(1, 0, 3'b010, 32'h2, 32'h0, 5'd12, 0, 0, 0, 32'h0, 4'h0));
        mem_op(mk(1, 1, 3'b010, 32'h0, 32'h0, 5'd12, 0, 0, 0, 32'h0, 4'h0));
        // T6: timeouts and reset during a load response
        mem_op(mk(1, 0, 3'b010, 32'h0, 32'h0, 5'd13, 10, 0, 0, 32'h0, 4'h0));
        mem_op(mk(1, 0, 3'b010, 32'h4, 32'h0, 5'd14, 0, 10, 0, 32'h0, 4'h0));
        mem_op(mk(0, 1, 3'b010, 32'h8, 32'h11112222, 5'd0, 10, 0, 0, 32'h0, 4'h0));
        mem_op(mk(1, 0, 3'b010, 32'h4, 32'h0, 5'd15, 3, 0, 1, 32'h12345678, 4'h0));
        o = mk(1, 0, 3'b010, 32'h0, 32'h0, 5'd16, 0, 0, 0, 32'h0, 4'h0);
        o.abort = 1'b1;
        mem_op(o);
        alu(5'd17, 32'h00000042, 1'b1, 1'b1, 32'h00000042);
        @(negedge clk);
        set_idle();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
